// File: rtl/mix_iq_decim.sv
// fs/4 quadrature mixer plus integrate-and-dump decimator for the 1-bit comparator stream.
// Optional macro MIX_MAG_EN adds the registered |I|+|Q| magnitude on mag_o.

module mix_iq_chan #(
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dump,
    input  logic [1:0]       prod,
    output logic [ACC_W-1:0] sum
`ifdef MIX_MAG_EN
    ,
    output logic [ACC_W-1:0] mag_part
`endif
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_nxt;

    // prod is a 2-bit two's complement value in {-1, 0, +1}
    assign sum_nxt = acc + {{(ACC_W-2){prod[1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sum <= '0;
        end else if (!en) begin
            acc <= '0;
        end else if (dump) begin
            acc <= '0;
            sum <= sum_nxt;
        end else begin
            acc <= sum_nxt;
        end
    end

`ifdef MIX_MAG_EN
    logic [ACC_W-1:0] abs_nxt;

    // The most negative code is unreachable, so the negation cannot overflow
    assign abs_nxt = sum_nxt[ACC_W-1] ? (ACC_W'(0) - sum_nxt) : sum_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_part <= '0;
        end else if (en && dump) begin
            mag_part <= abs_nxt;
        end
    end
`endif
endmodule

module mix_iq_decim #(
    parameter int DECIM = 10,
    parameter int ACC_W = 12,
    parameter int FRM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             comp,
    output logic [ACC_W-1:0] i_o,
    output logic [ACC_W-1:0] q_o,
    output logic             valid_o,
    output logic [FRM_W-1:0] frm_o,
    output logic [ACC_W:0]   mag_o
);
    localparam int CNT_W = $clog2(DECIM);
    localparam int NCH   = 2;

    if (DECIM < 2 || DECIM > 1024) begin : g_bad_decim
        $error("mix_iq_decim: DECIM out of range");
    end
    if (ACC_W < $clog2(DECIM) + 2) begin : g_bad_accw
        $error("mix_iq_decim: ACC_W too narrow for DECIM");
    end

    logic [1:0]                  ph;
    logic [CNT_W-1:0]            cnt;
    logic                        dump;
    logic [NCH-1:0][1:0]         prod;
    logic [NCH-1:0][ACC_W-1:0]   sum;

    assign dump = en && (cnt == CNT_W'(DECIM - 1));

    // LO products: 01 = +1, 11 = -1, 00 = 0; channel 0 is I, channel 1 is Q
    always_comb begin
        prod = '0;
        case (ph)
            2'd0: prod[0] = comp ? 2'b01 : 2'b11;
            2'd1: prod[1] = comp ? 2'b11 : 2'b01;
            2'd2: prod[0] = comp ? 2'b11 : 2'b01;
            default: prod[1] = comp ? 2'b01 : 2'b11;
        endcase
    end

    // Phase runs freely across frames; only en low or reset realigns it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      <= '0;
            cnt     <= '0;
            valid_o <= 1'b0;
            frm_o   <= '0;
        end else if (!en) begin
            ph      <= '0;
            cnt     <= '0;
            valid_o <= 1'b0;
        end else begin
            ph      <= ph + 2'd1;
            valid_o <= dump;
            if (dump) begin
                cnt   <= '0;
                frm_o <= frm_o + FRM_W'(1);
            end else begin
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef MIX_MAG_EN
    logic [NCH-1:0][ACC_W-1:0] mag_part;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        mix_iq_chan #(.ACC_W(ACC_W)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .dump     (dump),
            .prod     (prod[g]),
            .sum      (sum[g])
`ifdef MIX_MAG_EN
            ,
            .mag_part (mag_part[g])
`endif
        );
    end

    assign i_o = sum[0];
    assign q_o = sum[1];

`ifdef MIX_MAG_EN
    assign mag_o = {1'b0, mag_part[0]} + {1'b0, mag_part[1]};
`else
    assign mag_o = '0;
`endif
endmodule

// File: tb/tb_mix_iq_decim.sv
// Randomized bench for mix_iq_decim: DECIM=10 and DECIM=2 instances against a sample-count model.
module tb_mix_iq_decim;
    localparam int ACC_W = 12;
    localparam int FRM_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en0 = 1'b0, comp0 = 1'b0, en1 = 1'b0, comp1 = 1'b0;
    logic [ACC_W-1:0] i0, q0, i1, q1;
    logic v0, v1;
    logic [FRM_W-1:0] f0, f1;
    logic [ACC_W:0] m0, m1;
    bit done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mix_iq_decim #(.DECIM(10), .ACC_W(ACC_W), .FRM_W(FRM_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .comp(comp0),
        .i_o(i0), .q_o(q0), .valid_o(v0), .frm_o(f0), .mag_o(m0));

    mix_iq_decim #(.DECIM(2), .ACC_W(ACC_W), .FRM_W(FRM_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .comp(comp1),
        .i_o(i1), .q_o(q1), .valid_o(v1), .frm_o(f1), .mag_o(m1));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: everything derives from n = samples taken since en last rose
    int D[2] = '{10, 2};
    int ICOEF[4] = '{1, 0, -1, 0};
    int QCOEF[4] = '{0, -1, 0, 1};
    int n[2], ai[2], aq[2], ei[2], eq[2], ef[2], em[2];
    bit ev[2];

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic step(input int k, input logic e, input logic c);
        int s;
        if (!e) begin
            n[k] = 0; ai[k] = 0; aq[k] = 0; ev[k] = 0;
        end else begin
            s = c ? 1 : -1;
            ai[k] += s * ICOEF[n[k] % 4];
            aq[k] += s * QCOEF[n[k] % 4];
            if (n[k] % D[k] == D[k] - 1) begin
                ei[k] = ai[k]; eq[k] = aq[k];
`ifdef MIX_MAG_EN
                em[k] = iabs(ai[k]) + iabs(aq[k]);
`endif
                ev[k] = 1; ef[k] = (ef[k] + 1) % (1 << FRM_W);
                ai[k] = 0; aq[k] = 0;
            end else begin
                ev[k] = 0;
            end
            n[k]++;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            n[k] = 0; ai[k] = 0; aq[k] = 0; ei[k] = 0; eq[k] = 0; ef[k] = 0; em[k] = 0; ev[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    n[k] = 0; ai[k] = 0; aq[k] = 0; ei[k] = 0; eq[k] = 0; ef[k] = 0; em[k] = 0; ev[k] = 0;
                end
            end else begin
                step(0, en0, comp0);
                step(1, en1, comp1);
            end
            #1;
            chk("i0", $signed(i0), ei[0]);
            chk("q0", $signed(q0), eq[0]);
            chk("v0", v0, ev[0]);
            chk("f0", f0, ef[0]);
            chk("m0", m0, em[0]);
            chk("i1", $signed(i1), ei[1]);
            chk("q1", $signed(q1), eq[1]);
            chk("v1", v1, ev[1]);
            chk("f1", f1, ef[1]);
            chk("m1", m1, em[1]);
        end
    end

    task automatic wait_v0(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!v0 && cyc < 200);
        if (!v0) begin
            n_cmp++; n_bad++;
            $display("FAIL valid0_timeout: got no strobe, expected one within 200 cycles");
        end
    endtask

    // DECIM=2 instance: alternating comp literal checks, then random traffic
    initial begin
        @(posedge rst_n);
        for (int j = 0; j < 20; j++) begin
            en1 = 1'b1;
            comp1 = (j % 2 == 0);
            @(posedge clk); #1;
            chk("lit_d2_valid", v1, (j % 2 == 1) ? 1 : 0);
            if (j % 2 == 1) begin
                chk("lit_d2_i", $signed(i1), (j % 4 == 1) ? 1 : -1);
                chk("lit_d2_q", $signed(q1), (j % 4 == 1) ? 1 : -1);
`ifdef MIX_MAG_EN
                chk("lit_d2_mag", m1, 2);
`endif
            end
            @(negedge clk);
        end
        while (!done) begin
            en1 = ($urandom_range(0, 15) != 0);
            comp1 = 1'($urandom);
            @(negedge clk);
        end
    end

    initial begin
        int c;
        int vcnt;
        bit [3:0] pat;
        pat = 4'b0011;
        #1000000;
        $display("FAIL global_timeout: got no finish, expected end of run");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int vcnt;
        bit [3:0] pat;
        pat = 4'b0011;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_i", i0, 0); chk("rst_q", q0, 0); chk("rst_v", v0, 0);
        chk("rst_f", f0, 0); chk("rst_m", m0, 0);

        // comp held 1: frames (+1,-1) then (-1,+1), strobe every 10 cycles
        rst_n = 1'b1; en0 = 1'b1; comp0 = 1'b1;
        wait_v0(c);
        chk("t1_lat", c, 10); chk("t1_i", $signed(i0), 1); chk("t1_q", $signed(q0), -1); chk("t1_f", f0, 1);
        wait_v0(c);
        chk("t1_per", c, 10); chk("t1_i2", $signed(i0), -1); chk("t1_q2", $signed(q0), 1); chk("t1_f2", f0, 2);

        // comp 1,1,0,0 aligned to phase 0: every frame (+5,-5)
        @(negedge clk); en0 = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            en0 = 1'b1;
            comp0 = pat[j % 4];
            @(posedge clk); #1;
            if (j == 9 || j == 19) begin
                chk("t2_v", v0, 1); chk("t2_i", $signed(i0), 5); chk("t2_q", $signed(q0), -5);
`ifdef MIX_MAG_EN
                chk("t2_mag", m0, 10);
`endif
            end
            @(negedge clk);
        end

        // en dropped at cnt=5 for 3 cycles: partial frame discarded
        en0 = 1'b0;
        @(negedge clk);
        en0 = 1'b1; comp0 = 1'b1;
        repeat (5) @(negedge clk);
        en0 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("t3_gap_v", v0, 0);
            @(negedge clk);
        end
        en0 = 1'b1;
        wait_v0(c);
        chk("t3_lat", c, 10); chk("t3_i", $signed(i0), 1); chk("t3_q", $signed(q0), -1);

        // Asynchronous reset mid-frame
        @(negedge clk);
        repeat (4) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t4_i", i0, 0); chk("t4_q", q0, 0); chk("t4_v", v0, 0); chk("t4_f", f0, 0); chk("t4_m", m0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_v0(c);
        chk("t4_lat", c, 10); chk("t4_i2", $signed(i0), 1); chk("t4_q2", $signed(q0), -1); chk("t4_f2", f0, 1);

        // Random traffic until the frame counter wraps
        vcnt = 1;
        c = 0;
        while (vcnt < 256 && c < 20000) begin
            @(negedge clk);
            en0 = ($urandom_range(0, 31) != 0);
            comp0 = 1'($urandom);
            @(posedge clk); #1;
            c++;
            if (v0) begin
                vcnt++;
                if (vcnt == 255) chk("t5_f255", f0, 255);
                if (vcnt == 256) chk("t5_wrap", f0, 0);
            end
        end
        if (vcnt < 256) begin
            n_cmp++; n_bad++;
            $display("FAIL t5_frames: got %0d strobes, expected 256", vcnt);
        end

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
